// File: rtl/rx_frame_fifo.sv
// Receive-frame FIFO: captures one frame per rising edge of RX_Done_Sig into a DEPTH-entry memory,
// presented through a registered valid/ready output stage. Optional drop counter: RX_FRAME_DROP_CNT_EN.
module rx_frame_fifo #(
    parameter int FRAME_BYTES = 7,
    parameter int DEPTH       = 4,
    parameter int AW          = 2
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     RX_Done_Sig,
    input  logic [FRAME_BYTES*8-1:0] RX_Data,
    input  logic                     Out_Ready,
    input  logic                     Clear_Ovf,
    output logic                     Out_Valid,
    output logic [FRAME_BYTES*8-1:0] Number_Data,
    output logic                     RX_En_Sig,
    output logic [AW+1:0]            Level,
    output logic                     Overflow
`ifdef RX_FRAME_DROP_CNT_EN
    ,
    output logic [7:0]               Drop_Count
`endif
);

    localparam int W = FRAME_BYTES * 8;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          done_q;
    logic          valid_q;
    logic [W-1:0]  data_q;
    logic          ovf_q;

    logic wr, full, load, wr_ok, drop;

    always_comb begin
        wr    = RX_Done_Sig & ~done_q;
        full  = (count_q == DEPTH_C);
        load  = (~valid_q | Out_Ready) & (count_q != '0);
        // When full, a same-cycle pop frees the slot being written.
        wr_ok = wr & (~full | load);
        drop  = wr & full & ~load;
        count_d = count_q;
        if (wr_ok & ~load) begin
            count_d = count_q + 1'b1;
        end else if (~wr_ok & load) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            done_q  <= RX_Done_Sig;
            count_q <= count_d;
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (load) begin
                data_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
                valid_q  <= 1'b1;
            end else if (valid_q & Out_Ready) begin
                valid_q <= 1'b0;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (Clear_Ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= RX_Data;
        end
    end

`ifdef RX_FRAME_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            drop_cnt_q <= 8'd0;
        end else if (Clear_Ovf) begin
            drop_cnt_q <= drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign Drop_Count = drop_cnt_q;
`endif

    assign Out_Valid   = valid_q;
    assign Number_Data = data_q;
    assign Overflow    = ovf_q;
    assign RX_En_Sig   = ~full;
    assign Level       = {1'b0, count_q} + {{(AW+1){1'b0}}, valid_q};

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Bench for rx_frame_fifo: queue-based reference model compared every cycle, directed scenarios
// with literal expectations, then a randomized phase.
module tb_rx_frame_fifo;

    localparam int FB    = 7;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int W     = FB * 8;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          RX_Done_Sig = 1'b0;
    logic [W-1:0]  RX_Data = '0;
    logic          Out_Ready = 1'b0;
    logic          Clear_Ovf = 1'b0;
    logic          Out_Valid;
    logic [W-1:0]  Number_Data;
    logic          RX_En_Sig;
    logic [AW+1:0] Level;
    logic          Overflow;
`ifdef RX_FRAME_DROP_CNT_EN
    logic [7:0]    Drop_Count;
`endif

    rx_frame_fifo #(.FRAME_BYTES(FB), .DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .RSTn(RSTn), .RX_Done_Sig(RX_Done_Sig), .RX_Data(RX_Data),
        .Out_Ready(Out_Ready), .Clear_Ovf(Clear_Ovf), .Out_Valid(Out_Valid),
        .Number_Data(Number_Data), .RX_En_Sig(RX_En_Sig), .Level(Level),
        .Overflow(Overflow)
`ifdef RX_FRAME_DROP_CNT_EN
        , .Drop_Count(Drop_Count)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory as a queue, output stage as a valid flag plus data.
    logic [W-1:0] mq[$];
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    logic         m_ovf = 1'b0;
    logic         m_prev = 1'b0;
    int           m_drops = 0;
    bit           m_rise, m_drop;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mq.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_ovf   = 1'b0;
            m_prev  = 1'b0;
            m_drops = 0;
        end else begin
            m_rise = RX_Done_Sig && !m_prev;
            m_prev = RX_Done_Sig;
            m_drop = 1'b0;
            if ((!m_valid || Out_Ready) && mq.size() > 0) begin
                m_data  = mq.pop_front();
                m_valid = 1'b1;
            end else if (m_valid && Out_Ready) begin
                m_valid = 1'b0;
            end
            if (m_rise) begin
                if (mq.size() < DEPTH) mq.push_back(RX_Data);
                else m_drop = 1'b1;
            end
            if (m_drop) m_ovf = 1'b1;
            else if (Clear_Ovf) m_ovf = 1'b0;
            if (Clear_Ovf) m_drops = m_drop ? 1 : 0;
            else if (m_drop && m_drops < 255) m_drops++;
        end
    end

    always @(negedge CLK) begin
        chk("out_valid", 64'(Out_Valid), 64'(m_valid));
        chk("number_data", 64'(Number_Data), 64'(m_data));
        chk("level", 64'(Level), 64'(mq.size() + int'(m_valid)));
        chk("rx_en", 64'(RX_En_Sig), 64'(mq.size() != DEPTH));
        chk("overflow", 64'(Overflow), 64'(m_ovf));
`ifdef RX_FRAME_DROP_CNT_EN
        chk("drop_count", 64'(Drop_Count), 64'(m_drops));
`endif
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        RX_Data = d;
        RX_Done_Sig = 1'b1;
        tick();
        RX_Done_Sig = 1'b0;
        tick();
    endtask

    task automatic drain();
        Out_Ready = 1'b1;
        repeat (7) tick();
        Out_Ready = 1'b0;
    endtask

    logic [W-1:0] fr [6];
    logic [63:0]  r64;

    initial begin
        for (int i = 0; i < 6; i++) fr[i] = 56'h11223344556600 + W'(i);

        // Reset values
        repeat (2) tick();
        chk("rst_valid", 64'(Out_Valid), 64'd0);
        chk("rst_data", 64'(Number_Data), 64'd0);
        chk("rst_level", 64'(Level), 64'd0);
        chk("rst_rx_en", 64'(RX_En_Sig), 64'd1);
        chk("rst_ovf", 64'(Overflow), 64'd0);
        RSTn = 1'b1;
        tick();

        // Single frame, 2-clock latency
        RX_Data = 56'h01_03_00_00_00_0A_C5;
        RX_Done_Sig = 1'b1;
        tick();
        RX_Done_Sig = 1'b0;
        chk("single_valid_k", 64'(Out_Valid), 64'd0);
        chk("single_level_k", 64'(Level), 64'd1);
        tick();
        chk("single_valid_k1", 64'(Out_Valid), 64'd1);
        chk("single_data", 64'(Number_Data), 64'h01_03_00_00_00_0A_C5);
        chk("single_level", 64'(Level), 64'd1);
        chk("single_rx_en", 64'(RX_En_Sig), 64'd1);
        drain();

        // Held strobe
        RX_Data = 56'hAB_CD_EF_01_23_45_67;
        RX_Done_Sig = 1'b1;
        repeat (5) tick();
        RX_Done_Sig = 1'b0;
        repeat (2) tick();
        chk("held_level", 64'(Level), 64'd1);
        drain();

        // Fill and overflow
        for (int i = 0; i < 5; i++) push(fr[i]);
        chk("fill5_level", 64'(Level), 64'd5);
        chk("fill5_ovf", 64'(Overflow), 64'd0);
        push(fr[5]);
        chk("fill6_level", 64'(Level), 64'd5);
        chk("fill6_rx_en", 64'(RX_En_Sig), 64'd0);
        chk("fill6_ovf", 64'(Overflow), 64'd1);
`ifdef RX_FRAME_DROP_CNT_EN
        chk("fill6_dropcnt", 64'(Drop_Count), 64'd1);
`endif
        Out_Ready = 1'b1;
        chk("drain_0", 64'(Number_Data), 64'(fr[0]));
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("drain_order", 64'(Number_Data), 64'(fr[i]));
        end
        tick();
        chk("drain_empty_valid", 64'(Out_Valid), 64'd0);
        chk("drain_empty_level", 64'(Level), 64'd0);
        Out_Ready = 1'b0;
        Clear_Ovf = 1'b1;
        tick();
        Clear_Ovf = 1'b0;
        chk("clear_ovf", 64'(Overflow), 64'd0);

        // Full plus simultaneous pop
        for (int i = 0; i < 5; i++) push(fr[i]);
        RX_Data = 56'hDE_AD_BE_EF_00_11_22;
        RX_Done_Sig = 1'b1;
        Out_Ready = 1'b1;
        tick();
        RX_Done_Sig = 1'b0;
        Out_Ready = 1'b0;
        chk("fullpop_level", 64'(Level), 64'd5);
        chk("fullpop_ovf", 64'(Overflow), 64'd0);
        tick();

        // Clear racing a drop
        RX_Data = 56'h55_55_55_55_55_55_55;
        RX_Done_Sig = 1'b1;
        Clear_Ovf = 1'b1;
        tick();
        chk("race_ovf", 64'(Overflow), 64'd1);
        RX_Done_Sig = 1'b0;
        Clear_Ovf = 1'b0;
        tick();
        Clear_Ovf = 1'b1;
        tick();
        Clear_Ovf = 1'b0;
        chk("race_clear", 64'(Overflow), 64'd0);
        drain();

        // Reset mid-operation
        for (int i = 0; i < 3; i++) push(fr[i]);
        chk("pre_rst_level", 64'(Level), 64'd3);
        #2;
        RSTn = 1'b0;
        #1;
        chk("midrst_valid", 64'(Out_Valid), 64'd0);
        chk("midrst_data", 64'(Number_Data), 64'd0);
        chk("midrst_level", 64'(Level), 64'd0);
        tick();
        tick();
        RSTn = 1'b1;
        tick();
        RX_Data = 56'h77_66_55_44_33_22_11;
        RX_Done_Sig = 1'b1;
        tick();
        RX_Done_Sig = 1'b0;
        chk("post_rst_valid_k", 64'(Out_Valid), 64'd0);
        tick();
        chk("post_rst_valid_k1", 64'(Out_Valid), 64'd1);
        chk("post_rst_data", 64'(Number_Data), 64'h77_66_55_44_33_22_11);
        drain();

        // Randomized traffic with varying backpressure
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 600; c++) begin
                r64 = {$urandom(), $urandom()};
                RX_Data = r64[W-1:0];
                RX_Done_Sig = ($urandom_range(0, 9) < 5);
                Out_Ready = ($urandom_range(0, 3) < ph);
                Clear_Ovf = ($urandom_range(0, 31) == 0);
                tick();
            end
        end
        RX_Done_Sig = 1'b0;
        Clear_Ovf = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
